// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Debounces the start/stop, lap and clear buttons and runs the
//               stopwatch state machine. Keeps a 4-digit BCD time count
//               that advances once every CLK_DIV clocks while running.
// Revision    : 1.0  initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int CLK_DIV         = 120000,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [15:0] display_value,
    output logic        running,
    output logic        lap_active,
    output logic        wrap
);

    localparam int             PW        = $clog2(CLK_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);
    localparam int             DW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0]  DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_LAP    = 2'd2,
        S_PAUSED = 2'd3
    } state_t;

    state_t        state;
    logic [15:0]   count;
    logic [15:0]   lap_hold;
    logic [PW-1:0] presc;
    logic [1:0]    flush;
    logic          flushed;
    logic [2:0]    btn_raw;
    logic [2:0]    press;
    logic          ev_start;
    logic          ev_lap;
    logic          ev_clear;
    logic          run_phase;
    logic          tick;

    // Button index: 0 = start/stop, 1 = lap, 2 = clear
    assign btn_raw = {btn_clear, btn_lap, btn_start_stop};

    // The synchroniser output is only meaningful two edges after reset; this
    // lets each button learn whether it was already held when reset released.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flush <= 2'd0;
        end else if (flush != 2'd2) begin
            flush <= flush + 2'd1;
        end
    end

    assign flushed = (flush == 2'd2);

    for (genvar i = 0; i < 3; i++) begin : g_deb
        logic          s1;
        logic          s2;
        logic          level;
        logic          level_d;
        logic          armed;
        logic [DW-1:0] cnt;

        // Synchronise, debounce, and arm the press detector once the button is seen released
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                s1      <= 1'b0;
                s2      <= 1'b0;
                level   <= 1'b0;
                level_d <= 1'b0;
                armed   <= 1'b0;
                cnt     <= '0;
            end else begin
                s1      <= btn_raw[i];
                s2      <= s1;
                level_d <= level;
                if (flushed && !s2) begin
                    armed <= 1'b1;
                end
                if (s2 == level) begin
                    cnt <= '0;
                end else if (cnt == DB_MAX) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + DW'(1);
                end
            end
        end

        // A held-through-reset button never arms until released, so it cannot fire
        assign press[i] = level & ~level_d & armed;
    end

    // Priority clear > start > lap; losers in the same cycle are dropped
    assign ev_clear  = press[2];
    assign ev_start  = press[0] & ~press[2];
    assign ev_lap    = press[1] & ~press[0] & ~press[2];

    assign run_phase = (state == S_RUN) || (state == S_LAP);
    assign tick      = run_phase && (presc == PRESC_MAX);

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (v[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Prescaler, BCD time count and the rollover pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
            count <= 16'h0000;
            wrap  <= 1'b0;
        end else begin
            wrap <= tick && (count == 16'h9999);
            if ((state == S_PAUSED) && ev_clear) begin
                presc <= '0;
                count <= 16'h0000;
            end else if ((state == S_IDLE) && ev_start) begin
                presc <= '0;
            end else if (run_phase) begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) begin
                    count <= bcd_inc(count);
                end
            end
        end
    end

    // Control state machine with registered status outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
            lap_hold   <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ev_start) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (ev_start) begin
                        state   <= S_PAUSED;
                        running <= 1'b0;
                    end else if (ev_lap) begin
                        state      <= S_LAP;
                        lap_active <= 1'b1;
                        lap_hold   <= count;
                    end
                end
                S_LAP: begin
                    if (ev_lap) begin
                        state      <= S_RUN;
                        lap_active <= 1'b0;
                    end else if (ev_start) begin
                        state      <= S_PAUSED;
                        running    <= 1'b0;
                        lap_active <= 1'b0;
                    end
                end
                S_PAUSED: begin
                    if (ev_clear) begin
                        state    <= S_IDLE;
                        lap_hold <= 16'h0000;
                    end else if (ev_start) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    running    <= 1'b0;
                    lap_active <= 1'b0;
                end
            endcase
        end
    end

    assign display_value = lap_active ? lap_hold : count;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Randomised button stimulus for stopwatch_ctrl, compared every
//               cycle against an arithmetic model of elapsed running time.
// Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int CLK_DIV  = 4;
    localparam int DEB      = 3;
    localparam int LATENCY  = 3 + DEB;  // drive-to-action edges for a press
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_LAP    = 2;
    localparam int M_PAUSED = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        btn_start_stop = 1'b0;
    logic        btn_lap = 1'b0;
    logic        btn_clear = 1'b0;
    logic [15:0] display_value;
    logic        running;
    logic        lap_active;
    logic        wrap;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int ev_edge [3] = '{-1, -1, -1};
    int m_st = M_IDLE;
    int m_act = 0;
    logic [15:0] m_hold = 16'h0000;
    logic        m_wrap = 1'b0;
    bit   chk_en = 1'b0;
    int   wrap_seen = 0;

    stopwatch_ctrl #(
        .CLK_DIV         (CLK_DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .display_value  (display_value),
        .running        (running),
        .lap_active     (lap_active),
        .wrap           (wrap)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    // Reference model: time shown = active cycles / CLK_DIV, modulo 10000
    always @(posedge CLK) begin : model
        int nc;
        bit es, el, ec, act;
        int pre;
        nc  = cyc + 1;
        cyc <= nc;
        if (RST) begin
            m_st   <= M_IDLE;
            m_act  <= 0;
            m_hold <= 16'h0000;
            m_wrap <= 1'b0;
        end else begin
            ec  = (ev_edge[2] == nc);
            es  = (ev_edge[0] == nc) && !ec;
            el  = (ev_edge[1] == nc) && !ec && !es;
            act = (m_st == M_RUN) || (m_st == M_LAP);
            pre = (m_act / CLK_DIV) % 10000;
            m_wrap <= act && (((m_act + 1) % (CLK_DIV * 10000)) == 0);
            if (act) m_act <= m_act + 1;
            case (m_st)
                M_IDLE:   if (es) m_st <= M_RUN;
                M_RUN:    if (es) m_st <= M_PAUSED;
                          else if (el) begin m_st <= M_LAP; m_hold <= to_bcd(pre); end
                M_LAP:    if (el) m_st <= M_RUN;
                          else if (es) m_st <= M_PAUSED;
                default:  if (ec) begin m_st <= M_IDLE; m_act <= 0; m_hold <= 16'h0000; end
                          else if (es) m_st <= M_RUN;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge CLK) begin
        if (chk_en && !RST) begin
            check("display", display_value,
                  (m_st == M_LAP) ? m_hold : to_bcd((m_act / CLK_DIV) % 10000));
            check("running", running, (m_st == M_RUN) || (m_st == M_LAP));
            check("lap_active", lap_active, m_st == M_LAP);
            check("wrap", wrap, m_wrap);
            if (wrap) wrap_seen <= wrap_seen + 1;
        end
    end

    // mask bit0 start, bit1 lap, bit2 clear; called at a falling edge
    task automatic press(input int mask, input int hold, input int gap);
        btn_start_stop = mask[0];
        btn_lap        = mask[1];
        btn_clear      = mask[2];
        for (int b = 0; b < 3; b++) begin
            if (mask[b] && hold >= DEB) ev_edge[b] = cyc + LATENCY;
        end
        repeat (hold) @(negedge CLK);
        btn_start_stop = 1'b0;
        btn_lap        = 1'b0;
        btn_clear      = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        for (int b = 0; b < 3; b++) ev_edge[b] = -1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
    endtask

    initial begin
        int r, mask, w0;
        logic [15:0] frozen;
        repeat (3) @(negedge CLK);
        check("rst_display", display_value, 16'h0000);
        check("rst_running", running, 1'b0);
        check("rst_lap", lap_active, 1'b0);
        check("rst_wrap", wrap, 1'b0);
        RST = 1'b0;
        chk_en = 1'b1;
        repeat (5) @(negedge CLK);

        // Short glitch must be rejected
        press(1, 2, 20);
        check("glitch_running", running, 1'b0);
        check("glitch_display", display_value, 16'h0000);

        // Long hold gives a single start
        press(1, 10, 40);
        check("start_running", running, 1'b1);

        // Random button traffic
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            mask = (r < 4) ? 1 : (r < 7) ? 2 : (r < 9) ? 4 : 5;
            press(mask, DEB + $urandom_range(0, 6), $urandom_range(8, 60));
        end

        // Directed lap freeze and release
        do_reset();
        press(1, 4, 45);
        press(2, 4, 10);
        check("lap_on", lap_active, 1'b1);
        frozen = display_value;
        repeat (30) @(negedge CLK);
        check("lap_frozen", display_value, frozen);
        press(2, 4, 10);
        check("lap_off", lap_active, 1'b0);
        check("lap_live", display_value > frozen, 1'b1);

        // Asynchronous reset mid-run, button held across release
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("arst_display", display_value, 16'h0000);
        check("arst_running", running, 1'b0);
        check("arst_lap", lap_active, 1'b0);
        check("arst_wrap", wrap, 1'b0);
        for (int b = 0; b < 3; b++) ev_edge[b] = -1;
        @(negedge CLK);
        btn_start_stop = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (25) @(negedge CLK);
        check("held_no_press", running, 1'b0);
        btn_start_stop = 1'b0;
        repeat (15) @(negedge CLK);
        press(1, 5, 15);
        check("repress_running", running, 1'b1);

        // Full run through 0999->1000 and 9999->0000
        w0 = wrap_seen;
        repeat (10000 * CLK_DIV + 50) @(negedge CLK);
        check("wrap_pulses", wrap_seen - w0, 1);

        // Pause then clear
        press(1, 4, 20);
        check("pause_running", running, 1'b0);
        press(4, 4, 20);
        check("clear_display", display_value, 16'h0000);

        // Start and clear together while paused: clear wins
        press(1, 4, 30);
        press(1, 4, 20);
        press(5, 4, 20);
        check("sc_running", running, 1'b0);
        check("sc_display", display_value, 16'h0000);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
